// File: rtl/led_strobe_engine_pkg.sv
// Shared definitions for the LED strobe engine.
//   - pattern mode codes as they appear on the mode input
//   - FSM state encoding
//   - small elaboration-time helpers for sizing counters
package led_pkg;

  localparam logic [1:0] MODE_HALVES = 2'd0;
  localparam logic [1:0] MODE_ALL    = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FLASH_ON  = 2'd1,
    ST_FLASH_OFF = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_strobe_engine_if.sv
// Bus between the mode selector / tick source and the strobe engine.
//   master : drives tick, en, mode, led_select; observes led_out, busy, burst_done
//   slave  : the strobe engine itself
interface led_strobe_engine_if #(
  parameter int N_LED = 8
);

  logic             tick;
  logic             en;
  logic [1:0]       mode;
  logic [N_LED-1:0] led_select;
  logic [N_LED-1:0] led_out;
  logic             busy;
  logic             burst_done;

  modport master (
    output tick, en, mode, led_select,
    input  led_out, busy, burst_done
  );

  modport slave (
    input  tick, en, mode, led_select,
    output led_out, busy, burst_done
  );

endinterface

// File: rtl/led_pattern_gen.sv
// Combinational LED pattern for the current burst.
//   mode    : shadowed pattern mode (HALVES / ALL / CHASE / OFF)
//   phase   : HALVES selector, 0 = upper half lit, 1 = lower half lit
//   idx     : CHASE position (single lit bit)
//   mask    : shadowed per-LED enable mask
//   pattern : N_LED-bit drive value, already masked
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED = 8
) (
  input  logic [1:0]              mode,
  input  logic                    phase,
  input  logic [cnt_w(N_LED)-1:0] idx,
  input  logic [N_LED-1:0]        mask,
  output logic [N_LED-1:0]        pattern
);

  localparam logic [N_LED-1:0] UPPER = {{(N_LED/2){1'b1}}, {(N_LED/2){1'b0}}};
  localparam logic [N_LED-1:0] ONE   = N_LED'(1);

  logic [N_LED-1:0] raw;

  always_comb begin
    raw = '0;
    case (mode)
      MODE_HALVES: raw = phase ? ~UPPER : UPPER;
      MODE_ALL:    raw = '1;
      MODE_CHASE:  raw = ONE << idx;
      default:     raw = '0;
    endcase
  end

  // A masked-off chase position simply yields a dark pattern.
  assign pattern = raw & mask;

endmodule

// File: rtl/led_strobe_engine.sv
// Multi-mode LED strobe driver.
// Emits bursts of BURST flashes (ON_TICKS lit, OFF_TICKS dark between
// flashes) followed by GAP_TICKS dark ticks, all paced by the tick input.
// Mode and mask are sampled only when a burst starts; dropping en lets the
// current burst finish and then skips the gap.
//   clk, rst        : clock, asynchronous active-high reset
//   bus.tick        : one-clk pacing pulse; every duration counts ticks
//   bus.en          : run request
//   bus.mode        : pattern select (HALVES, ALL, CHASE, OFF)
//   bus.led_select  : per-LED enable mask
//   bus.led_out     : registered LED drive, lit only during ON phases
//   bus.busy        : high while a burst or gap is running
//   bus.burst_done  : one-clk pulse as the final ON phase of a burst ends
module led_strobe_engine
  import led_pkg::*;
#(
  parameter int N_LED     = 8,
  parameter int ON_TICKS  = 100,
  parameter int OFF_TICKS = 100,
  parameter int BURST     = 3,
  parameter int GAP_TICKS = 300
) (
  input  logic                clk,
  input  logic                rst,
  led_strobe_engine_if.slave  bus
);

  localparam int DUR_W   = cnt_w(max3(ON_TICKS, OFF_TICKS, GAP_TICKS));
  localparam int FLASH_W = cnt_w(BURST);
  localparam int IDX_W   = cnt_w(N_LED);

  localparam logic [DUR_W-1:0]   ON_LAST    = DUR_W'(ON_TICKS - 1);
  localparam logic [DUR_W-1:0]   OFF_LAST   = DUR_W'(OFF_TICKS - 1);
  localparam logic [DUR_W-1:0]   GAP_LAST   = DUR_W'(GAP_TICKS - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(BURST - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_LED - 1);

  state_t             state_q, state_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [FLASH_W-1:0] flash_q, flash_d;
  logic               phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         mode_sh_q, mode_sh_d;
  logic [N_LED-1:0]   sel_sh_q, sel_sh_d;
  logic [N_LED-1:0]   pattern;
  logic [N_LED-1:0]   led_q;
  logic               busy_q;
  logic               done_q;
  logic               start_ok;
  logic               latch;
  logic               burst_end;

  assign start_ok = bus.en && (bus.mode != MODE_OFF);

  // Next-state logic; nothing moves without a tick.
  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    flash_d   = flash_q;
    latch     = 1'b0;
    burst_end = 1'b0;
    if (bus.tick) begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            latch   = 1'b1;
            state_d = ST_FLASH_ON;
            dur_d   = '0;
            flash_d = '0;
          end
        end
        ST_FLASH_ON: begin
          if (dur_q == ON_LAST) begin
            dur_d = '0;
            if (flash_q < FLASH_LAST) begin
              state_d = ST_FLASH_OFF;
            end else begin
              // Gap is skipped entirely when en has been dropped.
              burst_end = 1'b1;
              state_d   = bus.en ? ST_GAP : ST_IDLE;
            end
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        ST_FLASH_OFF: begin
          if (dur_q == OFF_LAST) begin
            dur_d   = '0;
            flash_d = flash_q + FLASH_W'(1);
            state_d = ST_FLASH_ON;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        ST_GAP: begin
          if (dur_q == GAP_LAST) begin
            // Gap end re-applies the burst start rule with fresh settings.
            dur_d   = '0;
            flash_d = '0;
            latch   = 1'b1;
            state_d = start_ok ? ST_FLASH_ON : ST_IDLE;
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          dur_d   = '0;
          flash_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    if (burst_end) begin
      phase_d = ~phase_q;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // The pattern for a starting burst must use the settings latched on this
  // same edge, so the generator sees the next shadow values.
  assign mode_sh_d = latch ? bus.mode : mode_sh_q;
  assign sel_sh_d  = latch ? bus.led_select : sel_sh_q;

  led_pattern_gen #(
    .N_LED (N_LED)
  ) u_pattern_gen (
    .mode    (mode_sh_d),
    .phase   (phase_q),
    .idx     (idx_q),
    .mask    (sel_sh_d),
    .pattern (pattern)
  );

  // Control, pointers and outputs register together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      flash_q <= '0;
      phase_q <= 1'b0;
      idx_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      flash_q <= flash_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      led_q   <= (state_d == ST_FLASH_ON) ? pattern : '0;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= burst_end;
    end
  end

  // Shadow settings are data, always written before use on burst start.
  always_ff @(posedge clk) begin
    mode_sh_q <= mode_sh_d;
    sel_sh_q  <= sel_sh_d;
  end

  assign bus.led_out    = led_q;
  assign bus.busy       = busy_q;
  assign bus.burst_done = done_q;

endmodule

// File: doc/led_strobe_engine.md
# led_strobe_engine

Parametrised multi-mode strobe driver for the LED bank, the next generation of the fixed two-group blink driver. It emits bursts of ON/OFF flashes separated by a dark gap. Three patterns are supported: alternate halves, all together, and a single-LED chase. Mode and LED mask are taken per burst, and bursts stop cleanly when disabled. It sits between the mode selector and the LED output mux, and is paced by the shared slow tick.

## Interface
- N_LED, 8: number of LEDs; must be even and ≥2.
- ON_TICKS, 100: ticks per flash ON phase; ≥1.
- OFF_TICKS, 100: ticks per OFF phase between flashes inside a burst; ≥1.
- BURST, 3: flashes per burst; ≥1.
- GAP_TICKS, 300: dark ticks between bursts; ≥1.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-clk pacing pulse, e.g. 600 Hz; all durations are counted in ticks.
- en  in  1  run request.
- mode  in  2  pattern select: 0 HALVES, 1 ALL, 2 CHASE, 3 OFF.
- led_select  in  N_LED  per-LED enable mask.
- led_out  out  N_LED  registered LED drive.
- busy  out  1  high while a burst or gap is in progress.
- burst_done  out  1  one-clk pulse at the end of each burst's last ON phase.

## Operation
- States: IDLE, FLASH_ON, FLASH_OFF, GAP.
- All state changes occur only on clk edges with tick=1; a single duration counter is cleared on every state entry.
- IDLE → FLASH_ON on tick when en=1 and mode≠OFF.
  - mode and led_select are latched into shadow registers at this point.
  - The flash counter is cleared.
- FLASH_ON lasts ON_TICKS ticks, then:
  - if flashes < BURST: go to FLASH_OFF;
  - else: pulse burst_done and go to GAP if en=1, or to IDLE if en=0.
- FLASH_OFF lasts OFF_TICKS ticks, then goes to FLASH_ON with flash count +1.
- GAP lasts GAP_TICKS ticks, then goes back through the IDLE entry rule: shadow registers are relatched, and if en=0 or mode=OFF the block goes to IDLE.
- At each burst end, pattern pointers advance (reset value 0):
  - `phase` toggles;
  - `idx` increments and wraps from N_LED-1 to 0.
- Pattern while in FLASH_ON, ANDed with the shadow led_select:
  - HALVES: phase 0 lights bits [N_LED-1:N_LED/2]; phase 1 lights bits [N_LED/2-1:0].
  - ALL: all bits.
  - CHASE: only bit idx. A masked-off idx gives a dark burst, which still consumes full burst timing.
- led_out is 0 in every state other than FLASH_ON.
- Live mode and led_select changes are ignored mid-burst and mid-gap. They take effect at the next burst start.
- en low mid-burst: the current burst completes, and the GAP is skipped.
- busy = (state ≠ IDLE).

## Timing
- Reset values: led_out=0, busy=0, burst_done=0, state=IDLE, phase=0, idx=0, all counters 0.
- led_out, busy and burst_done are registered. They update on the same clk edge as the state transition that causes them, i.e. one clk after the sampled tick edge.
- burst_done is high for exactly one clk, coinciding with led_out going to 0 at the end of the final ON phase.
- Period of one burst plus gap = BURST·ON_TICKS + (BURST-1)·OFF_TICKS + GAP_TICKS ticks.
- Counter widths are $clog2 of the largest duration, or of BURST; there is no overflow path.
- tick asserted on consecutive clocks is legal: each clk counts as one tick.
- Asynchronous rst mid-flash forces all outputs to 0 immediately. The first burst after release starts with phase=0 and idx=0.

## Structure
- Shared package `led_pkg`:
  - mode constants MODE_HALVES, MODE_ALL, MODE_CHASE, MODE_OFF;
  - state encoding.
- Sub-module `led_pattern_gen`: combinational mapping from (shadow mode, phase, idx, shadow mask) to an N_LED-bit pattern.
- Top level `led_strobe_engine`: FSM, counters, phase/idx pointers, shadow registers and output register.

## Test plan
Unless stated otherwise, parameters are N_LED=8, ON=2, OFF=1, BURST=2, GAP=3, with tick=1 every clk.

- Reset and idle:
  - assert rst mid-run → led_out=00, busy=0 immediately, before any clk edge;
  - en=0 → block stays IDLE indefinitely.
- ALL, select=FF, en=1 from cycle 0:
  - led_out on cycles 1..8 is FF,FF,00,FF,FF,00,00,00, then repeats from cycle 9;
  - burst_done high on cycle 6 only.
- HALVES, select=FF: successive bursts light F0, 0F, F0.
- CHASE:
  - select=FF → bursts light 01,02,04,…,80, then 01 (wrap);
  - select=05 → bursts 01, 00 (dark, full timing), 04.
- Mid-burst changes: switch mode to CHASE and select to 0F during burst 1 of ALL → burst 1 stays FF, new settings apply from burst 2.
- en dropped during the first ON of a burst → second flash still occurs, burst_done pulses, busy falls on that same cycle, no GAP follows.
